// File: rtl/crop_stream_writer_if.sv
// AXI-Stream style handshake bundle shared by the crop writer's input and output sides.
// Each modport carries only the sideband that its direction uses (tuser in, tlast out).
interface crop_stream_writer_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned USER_WIDTH = 2
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/crop_stream_writer.sv
// Captures an inclusive ROI from one camera frame into a buffer, then replays it downstream.
// Optional NORM_MAX_EN builds frame-maximum tracking for norm_denominator; otherwise it is constant 1.
module crop_stream_writer #(
    parameter int unsigned PIXEL_BIT_WIDTH = 10,
    parameter int unsigned USER_WIDTH      = 2,
    parameter int unsigned MAX_PIXELS      = 4096,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned COORD_WIDTH     = 12
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       overflow,
    input  logic [COORD_WIDTH-1:0]     x_start,
    input  logic [COORD_WIDTH-1:0]     x_end,
    input  logic [COORD_WIDTH-1:0]     y_start,
    input  logic [COORD_WIDTH-1:0]     y_end,
    crop_stream_writer_if.slave        s_axis,
    crop_stream_writer_if.master       m_axis,
    output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(MAX_PIXELS);

    logic [1:0]                 state;
    logic [COORD_WIDTH-1:0]     xs_q, xe_q, ys_q, ye_q;
    logic [COORD_WIDTH-1:0]     col, row, col_e, row_e;
    logic [ADDR_WIDTH:0]        wr_count, wc_e, rd_ptr;
    logic [USER_WIDTH-1:0]      user;
    logic                       sof, eol, accept, process, in_roi, keep, frame_end;

    logic [PIXEL_BIT_WIDTH-1:0] mem [MAX_PIXELS];
    logic [PIXEL_BIT_WIDTH-1:0] ram_q;
    logic                       q_valid, q_last;
    logic                       out_valid, out_last;
    logic [PIXEL_BIT_WIDTH-1:0] out_data;
    logic                       out_free, move, rd_en;

    assign user           = s_axis.tuser;
    assign s_axis.tready  = (state == WAIT_SOF) || (state == CAPTURE);
    assign ap_idle        = (state == IDLE);
    assign m_axis.tvalid  = out_valid;
    assign m_axis.tdata   = out_data;
    assign m_axis.tlast   = out_last;

    // A SOF beat is evaluated as line 0 / column 0 of a fresh frame, whether it ends WAIT_SOF or restarts CAPTURE.
    always_comb begin
        sof       = user[0];
        eol       = user[1];
        accept    = s_axis.tvalid && s_axis.tready;
        process   = accept && ((state == CAPTURE) || ((state == WAIT_SOF) && sof));
        col_e     = sof ? '0 : col;
        row_e     = sof ? '0 : row;
        wc_e      = sof ? '0 : wr_count;
        in_roi    = (col_e >= xs_q) && (col_e <= xe_q) && (row_e >= ys_q) && (row_e <= ye_q);
        keep      = in_roi && (wc_e != FULL);
        frame_end = process && eol && (row_e == ye_q);
    end

    // Read pipeline: RAM output stage (q_*) feeding the output register (out_*).
    always_comb begin
        out_free = !out_valid || m_axis.tready;
        move     = q_valid && out_free;
        rd_en    = (state == DRAIN) && (rd_ptr != wr_count) && (!q_valid || move);
    end

    always_ff @(posedge clk) begin
        if (process && keep) begin
            mem[wc_e[ADDR_WIDTH-1:0]] <= s_axis.tdata;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state     <= IDLE;
            ap_done   <= 1'b0;
            overflow  <= 1'b0;
            xs_q      <= '0;
            xe_q      <= '0;
            ys_q      <= '0;
            ye_q      <= '0;
            col       <= '0;
            row       <= '0;
            wr_count  <= '0;
            rd_ptr    <= '0;
            q_valid   <= 1'b0;
            q_last    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        xs_q     <= x_start;
                        xe_q     <= x_end;
                        ys_q     <= y_start;
                        ye_q     <= y_end;
                        overflow <= 1'b0;
                        wr_count <= '0;
                        rd_ptr   <= '0;
                        q_valid  <= 1'b0;
                        state    <= WAIT_SOF;
                    end
                end
                WAIT_SOF, CAPTURE: begin
                    if (process) begin
                        wr_count <= wc_e + (ADDR_WIDTH+1)'(keep);
                        if (in_roi && !keep) begin
                            overflow <= 1'b1;
                        end
                        if (eol) begin
                            col <= '0;
                            row <= row_e + 1'b1;
                        end else begin
                            col <= col_e + 1'b1;
                            row <= row_e;
                        end
                        if (frame_end) begin
                            ap_done <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            state   <= CAPTURE;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        q_last  <= (rd_ptr == wr_count - 1'b1);
                        q_valid <= 1'b1;
                    end else if (move) begin
                        q_valid <= 1'b0;
                    end
                    if (move) begin
                        out_valid <= 1'b1;
                        out_data  <= ram_q;
                        out_last  <= q_last;
                    end else if (m_axis.tready) begin
                        out_valid <= 1'b0;
                    end
                    if ((wr_count == '0) || (out_valid && m_axis.tready && out_last)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NORM_MAX_EN
    logic [PIXEL_BIT_WIDTH-1:0] max_q, max_e, max_n, norm_q;

    always_comb begin
        max_e = sof ? '0 : max_q;
        max_n = (keep && (s_axis.tdata > max_e)) ? s_axis.tdata : max_e;
    end

    // With nothing stored max_n is still 0, so an empty ROI yields norm 0 with no extra check.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            max_q  <= '0;
            norm_q <= '0;
        end else if ((state == IDLE) && ap_start) begin
            max_q <= '0;
        end else if (process) begin
            max_q <= max_n;
            if (frame_end) begin
                norm_q <= max_n;
            end
        end
    end

    assign norm_denominator = norm_q;
`else
    assign norm_denominator = PIXEL_BIT_WIDTH'(1);
`endif

endmodule

// File: tb/tb_crop_stream_writer.sv
// Scoreboard bench for crop_stream_writer: expected ROI beats are queued as frames are driven.
// Define NORM_MAX_EN consistently for RTL and bench to check the frame-maximum output.
module tb_crop_stream_writer;

    localparam int PW   = 10;
    localparam int UW   = 2;
    localparam int MAXP = 16;
    localparam int AW   = 4;
    localparam int CW   = 12;

`ifdef NORM_MAX_EN
    localparam logic [PW-1:0] RST_NORM = '0;
`else
    localparam logic [PW-1:0] RST_NORM = PW'(1);
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic          ap_start;
    logic          ap_done, ap_idle, overflow;
    logic [CW-1:0] x_start, x_end, y_start, y_end;
    logic [PW-1:0] norm_denominator;

    crop_stream_writer_if #(.DATA_WIDTH(PW), .USER_WIDTH(UW)) s_if ();
    crop_stream_writer_if #(.DATA_WIDTH(PW), .USER_WIDTH(UW)) m_if ();

    crop_stream_writer #(
        .PIXEL_BIT_WIDTH (PW),
        .USER_WIDTH      (UW),
        .MAX_PIXELS      (MAXP),
        .ADDR_WIDTH      (AW),
        .COORD_WIDTH     (CW)
    ) dut (
        .clk              (clk),
        .srst             (srst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .overflow         (overflow),
        .x_start          (x_start),
        .x_end            (x_end),
        .y_start          (y_start),
        .y_end            (y_end),
        .s_axis           (s_if.slave),
        .m_axis           (m_if.master),
        .norm_denominator (norm_denominator)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    logic [PW:0]   exp_q[$];
    int            cyc = 0;
    int            done_cnt, done_cyc, first_v, beats, last_acc_cyc, idle_after;
    logic [PW-1:0] done_norm;
    logic [PW-1:0] exp_norm;
    int            exp_n;
    bit            s_acc, stalled, bp;
    logic [PW:0]   held, got, want;

    // One clock: observe at the falling edge, return just after the rising edge so the caller can drive.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_acc = s_if.tvalid && s_if.tready;
        if (!srst) begin
            if (ap_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_norm = norm_denominator;
            end
            if (ap_idle && done_cnt > 0 && idle_after < 0) idle_after = cyc;
            if (m_if.tvalid && first_v < 0) first_v = cyc;
            got = {m_if.tlast, m_if.tdata};
            if (stalled && m_if.tvalid) begin
                vectors++;
                if (got !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h required %h", got, held);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                vectors++;
                beats++;
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_extra: got last/data %h, none expected", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL beat_%0d: got last/data %h required %h", beats, got, want);
                    end
                end
            end
            stalled = m_if.tvalid && !m_if.tready;
            held    = got;
        end else begin
            stalled = 1'b0;
        end
        @(posedge clk);
        #1;
        if (bp) m_if.tready = !m_if.tready;
    endtask

    task automatic clear_stats();
        done_cnt = 0; done_cyc = -1; first_v = -1; beats = 0;
        last_acc_cyc = -1; idle_after = -1; stalled = 1'b0;
    endtask

    task automatic start_run(input int xs, input int xe, input int ys, input int ye);
        clear_stats();
        x_start = CW'(xs); x_end = CW'(xe); y_start = CW'(ys); y_end = CW'(ye);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    // Reference ROI model: raster order, inclusive bounds, only the first MAXP pixels stored.
    task automatic expect_roi(input int w, input int h, input int off,
                              input int xs, input int xe, input int ys, input int ye);
        int n = 0;
        int k = 0;
        logic [PW-1:0] mx = '0;
        logic [PW-1:0] v;
        for (int l = 0; l < h; l++)
            for (int c = 0; c < w; c++)
                if (c >= xs && c <= xe && l >= ys && l <= ye && n < MAXP) n++;
        for (int l = 0; l < h; l++)
            for (int c = 0; c < w; c++)
                if (c >= xs && c <= xe && l >= ys && l <= ye && k < n) begin
                    v = PW'(off + l * w + c);
                    exp_q.push_back({(k == n - 1), v});
                    if (v > mx) mx = v;
                    k++;
                end
        exp_n = n;
`ifdef NORM_MAX_EN
        exp_norm = mx;
`else
        exp_norm = PW'(1);
`endif
    endtask

    task automatic drive_beat(input logic [PW-1:0] d, input logic [UW-1:0] u);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_acc = 1'b0;
        for (int t = 0; t < 8 && !s_acc; t++) tick();
        vectors++;
        if (!s_acc) begin
            miscompares++;
            $display("FAIL s_accept: got tready-timeout for data %0d required accept", d);
        end
    endtask

    // Drives npre garbage beats, then lines 0..h-1 of a w-wide frame (SOF on the first pixel).
    // nmax >= 0 truncates the frame; poke >= 0 pulses ap_start with different bounds on that beat.
    task automatic send_frame(input int w, input int h, input int off, input int npre,
                              input int nmax, input int poke);
        int k = 0;
        for (int p = 0; p < npre; p++)
            drive_beat(PW'($urandom_range(0, 1023)), (p % 2 == 1) ? 2'b10 : 2'b00);
        for (int l = 0; l < h; l++)
            for (int c = 0; c < w; c++)
                if (nmax < 0 || k < nmax) begin
                    if (k == poke) begin
                        ap_start = 1'b1;
                        x_start  = '0;
                        x_end    = CW'(w - 1);
                    end
                    drive_beat(PW'(off + l * w + c), {(c == w - 1), (l == 0 && c == 0)});
                    ap_start = 1'b0;
                    k++;
                end
        s_if.tvalid = 1'b0;
        s_if.tuser  = '0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int t = 0; t < 300 && to; t++) begin
            if (ap_idle && done_cnt > 0 && exp_q.size() == 0) to = 1'b0;
            else tick();
        end
        repeat (3) tick();
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL drain_timeout: got no idle, %0d beats pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({ap_idle, ap_done, overflow, s_if.tready, m_if.tvalid, m_if.tlast} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 100000",
                     {ap_idle, ap_done, overflow, s_if.tready, m_if.tvalid, m_if.tlast});
        end
        vectors++;
        if (m_if.tdata !== '0 || norm_denominator !== RST_NORM) begin
            miscompares++;
            $display("FAIL reset_data: got tdata %0d norm %0d required 0 %0d",
                     m_if.tdata, norm_denominator, RST_NORM);
        end
        srst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        bp = 1'b0; m_if.tready = 1'b1;
        start_run(2, 5, 1, 2);
        expect_roi(8, 3, 0, 2, 5, 1, 2);
        send_frame(8, 3, 0, 0, -1, -1);
        wait_idle(to);
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
        vectors++;
        if (first_v - done_cyc != 2) begin miscompares++; $display("FAIL basic_latency: got %0d required 2", first_v - done_cyc); end
        vectors++;
        if (beats != exp_n) begin miscompares++; $display("FAIL basic_beats: got %0d required %0d", beats, exp_n); end
        vectors++;
        if (done_norm !== exp_norm) begin miscompares++; $display("FAIL basic_norm: got %0d required %0d", done_norm, exp_norm); end
        vectors++;
        if (idle_after - last_acc_cyc != 1) begin miscompares++; $display("FAIL basic_idle: got %0d required 1", idle_after - last_acc_cyc); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_backpressure();
        bit to;
        bp = 1'b1; m_if.tready = 1'b0;
        start_run(2, 5, 1, 2);
        expect_roi(8, 3, 0, 2, 5, 1, 2);
        send_frame(8, 3, 0, 3, -1, -1);
        wait_idle(to);
        bp = 1'b0; m_if.tready = 1'b1;
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt); end
        vectors++;
        if (beats != 8) begin miscompares++; $display("FAIL bp_beats: got %0d required 8", beats); end
        vectors++;
        if (done_norm !== exp_norm) begin miscompares++; $display("FAIL bp_norm: got %0d required %0d", done_norm, exp_norm); end
    endtask

    task automatic test_midframe_sof();
        bit to;
        start_run(2, 5, 1, 2);
        send_frame(8, 3, 0, 0, 11, -1);
        expect_roi(8, 3, 100, 2, 5, 1, 2);
        send_frame(8, 3, 100, 0, -1, -1);
        wait_idle(to);
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL sof_done_cnt: got %0d required 1", done_cnt); end
        vectors++;
        if (beats != 8) begin miscompares++; $display("FAIL sof_beats: got %0d required 8", beats); end
        vectors++;
        if (done_norm !== exp_norm) begin miscompares++; $display("FAIL sof_norm: got %0d required %0d", done_norm, exp_norm); end
    endtask

    task automatic test_overflow();
        bit to;
        start_run(1, 5, 0, 4);
        expect_roi(8, 5, 0, 1, 5, 0, 4);
        send_frame(8, 5, 0, 0, -1, -1);
        wait_idle(to);
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        vectors++;
        if (beats != MAXP) begin miscompares++; $display("FAIL ovf_beats: got %0d required %0d", beats, MAXP); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL ovf_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_empty();
        bit to;
        start_run(6, 2, 1, 2);
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL empty_ovf_clear: got %b required 0", overflow); end
        expect_roi(8, 3, 0, 6, 2, 1, 2);
`ifdef NORM_MAX_EN
        exp_norm = '0;
`endif
        send_frame(8, 3, 0, 0, -1, -1);
        wait_idle(to);
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL empty_done_cnt: got %0d required 1", done_cnt); end
        vectors++;
        if (beats != 0) begin miscompares++; $display("FAIL empty_beats: got %0d required 0", beats); end
        vectors++;
        if (done_norm !== exp_norm) begin miscompares++; $display("FAIL empty_norm: got %0d required %0d", done_norm, exp_norm); end
        vectors++;
        if (idle_after - done_cyc < 1 || idle_after - done_cyc > 2) begin
            miscompares++;
            $display("FAIL empty_idle: got %0d cycles required 1..2", idle_after - done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        start_run(2, 5, 1, 2);
        expect_roi(8, 3, 0, 2, 5, 1, 2);
        send_frame(8, 3, 0, 0, -1, 12);
        wait_idle(to);
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL ign_done_cnt: got %0d required 1", done_cnt); end
        vectors++;
        if (beats != 8) begin miscompares++; $display("FAIL ign_beats: got %0d required 8", beats); end
    endtask

    task automatic test_reset_drain();
        bit to;
        bit reached = 1'b0;
        start_run(2, 5, 1, 2);
        expect_roi(8, 3, 0, 2, 5, 1, 2);
        send_frame(8, 3, 0, 0, -1, -1);
        for (int t = 0; t < 50 && !reached; t++) begin
            if (beats >= 3) reached = 1'b1;
            else tick();
        end
        vectors++;
        if (!reached) begin miscompares++; $display("FAIL rst_drain_reach: got %0d beats required 3", beats); end
        srst = 1'b1;
        #1;
        vectors++;
        if ({ap_idle, ap_done, overflow, s_if.tready, m_if.tvalid, m_if.tlast} !== 6'b100000) begin
            miscompares++;
            $display("FAIL rst_drain_flags: got %b required 100000",
                     {ap_idle, ap_done, overflow, s_if.tready, m_if.tvalid, m_if.tlast});
        end
        vectors++;
        if (norm_denominator !== RST_NORM) begin
            miscompares++;
            $display("FAIL rst_drain_norm: got %0d required %0d", norm_denominator, RST_NORM);
        end
        tick();
        srst = 1'b0;
        exp_q.delete();
        tick();
        start_run(2, 5, 1, 2);
        expect_roi(8, 3, 0, 2, 5, 1, 2);
        send_frame(8, 3, 0, 0, -1, -1);
        wait_idle(to);
        vectors++;
        if (beats != 8 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL rst_rerun: got %0d beats %0d done required 8 1", beats, done_cnt);
        end
    endtask

    initial begin
        srst = 1'b1; ap_start = 1'b0; bp = 1'b0;
        x_start = '0; x_end = '0; y_start = '0; y_end = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1; m_if.tuser = '0;
        clear_stats();
        test_reset();
        test_basic();
        test_backpressure();
        test_midframe_sof();
        test_overflow();
        test_empty();
        test_start_ignored();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
